// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared event geometry, receiver FSM states and counter helper.
package dvs_ravens_pkg;
  localparam int DVS_X_BITS = 8;
  localparam int DVS_Y_BITS = 8;
  localparam int EVENT_BITS = DVS_X_BITS + DVS_Y_BITS + 1;
  typedef logic [EVENT_BITS-1:0] event_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} aer_rx_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/dvs_aer_receiver_if.sv
// dvs_aer_receiver_if: camera AER handshake plus event-queue push bundle.
interface dvs_aer_receiver_if;
  import dvs_ravens_pkg::*;
  logic        aer_req;
  event_t      aer_addr;
  logic        aer_ack;
  logic        queue_full;
  event_t      event_out;
  logic        wr_en;
  logic [15:0] evt_count;
  logic        stall;
  modport slave (
    input  aer_req, aer_addr, queue_full,
    output aer_ack, event_out, wr_en, evt_count, stall
  );
  modport master (
    output aer_req, aer_addr, queue_full,
    input  aer_ack, event_out, wr_en, evt_count, stall
  );
endinterface

// File: rtl/dvs_sync_ff.sv
// dvs_sync_ff: multi-stage flip-flop synchronizer for a single asynchronous bit.
module dvs_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk) begin
    r_sync <= !rst_n ? '0 : {r_sync[STAGES-2:0], i_d};
  end
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/dvs_aer_receiver.sv
// dvs_aer_receiver: 4-phase AER receiver pushing captured camera events into a queue.
module dvs_aer_receiver
  import dvs_ravens_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  dvs_aer_receiver_if.slave  bus
);
  logic          w_req_s;
  aer_rx_state_t r_state;
  aer_rx_state_t w_next;
  logic          w_stall;
  logic          r_ack;
  logic          r_wr;
  event_t        r_event;
  logic [15:0]   r_evt_count;
  dvs_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.aer_req),
    .o_q   (w_req_s)
  );
  // aer_addr is bundled data: valid whenever the synchronized request is seen
  always_comb begin
    w_next  = r_state == IDLE    ? ((w_req_s && !bus.queue_full) ? CAPTURE : IDLE) :
              r_state == CAPTURE ? ACK :
              (w_req_s ? ACK : IDLE);
    w_stall = r_state == IDLE && w_req_s && bus.queue_full;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_wr        <= 1'b0;
      r_event     <= '0;
      r_evt_count <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_next == ACK;
      r_wr    <= w_next == CAPTURE;
      if (r_state == IDLE && w_next == CAPTURE) r_event <= bus.aer_addr;
      if (r_state == CAPTURE) r_evt_count <= sat_inc(r_evt_count);
    end
  end
  assign bus.aer_ack   = r_ack;
  assign bus.wr_en     = r_wr;
  assign bus.event_out = r_event;
  assign bus.evt_count = r_evt_count;
  assign bus.stall     = w_stall;
endmodule
